// File: rtl/snake_pkg.sv
// ============================================================================
// Module  : snake_pkg
// Purpose : Shared grid constants and scan-state encoding for the snake row
//           scanner and its line buffer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package snake_pkg;

    localparam int COORD_W = 7;
    localparam int GRID_W  = 128;
    localparam int MAX_SEG = 128;

    localparam logic [COORD_W-1:0] HEAD_IDX = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/snake_line_buffer.sv
// ============================================================================
// Module  : snake_line_buffer
// Purpose : Double-buffered row occupancy bitmap with head tracking and a
//           registered per-cell query port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module snake_line_buffer #(
    parameter int COORD_W = snake_pkg::COORD_W,
    parameter int GRID_W  = snake_pkg::GRID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_build,
    input  logic               wr_en,
    input  logic               wr_head,
    input  logic [COORD_W-1:0] wr_x,
    input  logic               commit,
    input  logic [COORD_W-1:0] cell_x,
    output logic               cell_hit,
    output logic               head_hit
);

    logic [GRID_W-1:0]  build_q, build_d;
    logic               build_head_valid_q, build_head_valid_d;
    logic [COORD_W-1:0] build_head_x_q, build_head_x_d;

    logic [GRID_W-1:0]  disp_q, disp_d;
    logic               disp_head_valid_q, disp_head_valid_d;
    logic [COORD_W-1:0] disp_head_x_q, disp_head_x_d;

    logic               cell_hit_q, cell_hit_d;
    logic               head_hit_q, head_hit_d;

    always_comb begin
        build_d            = build_q;
        build_head_valid_d = build_head_valid_q;
        build_head_x_d     = build_head_x_q;
        disp_d             = disp_q;
        disp_head_valid_d  = disp_head_valid_q;
        disp_head_x_d      = disp_head_x_q;

        if (clear_build) begin
            build_d            = '0;
            build_head_valid_d = 1'b0;
            build_head_x_d     = '0;
        end else if (wr_en) begin
            // Overlapping segments simply OR into the same cell.
            build_d[wr_x] = 1'b1;
            if (wr_head) begin
                build_head_valid_d = 1'b1;
                build_head_x_d     = wr_x;
            end
        end

        if (commit) begin
            disp_d            = build_q;
            disp_head_valid_d = build_head_valid_q;
            disp_head_x_d     = build_head_x_q;
        end

        cell_hit_d = disp_q[cell_x];
        head_hit_d = disp_head_valid_q && (disp_head_x_q == cell_x);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            build_q            <= '0;
            build_head_valid_q <= 1'b0;
            build_head_x_q     <= '0;
            disp_q             <= '0;
            disp_head_valid_q  <= 1'b0;
            disp_head_x_q      <= '0;
            cell_hit_q         <= 1'b0;
            head_hit_q         <= 1'b0;
        end else begin
            build_q            <= build_d;
            build_head_valid_q <= build_head_valid_d;
            build_head_x_q     <= build_head_x_d;
            disp_q             <= disp_d;
            disp_head_valid_q  <= disp_head_valid_d;
            disp_head_x_q      <= disp_head_x_d;
            cell_hit_q         <= cell_hit_d;
            head_hit_q         <= head_hit_d;
        end
    end

    assign cell_hit = cell_hit_q;
    assign head_hit = head_hit_q;

endmodule

`default_nettype wire

// File: rtl/snake_line_scanner.sv
// ============================================================================
// Module  : snake_line_scanner
// Purpose : Walks the snake segment store once per display row and builds the
//           row occupancy bitmap queried by the pixel path.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module snake_line_scanner #(
    parameter int COORD_W = snake_pkg::COORD_W,
    parameter int GRID_W  = snake_pkg::GRID_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_y,
    input  logic [COORD_W-1:0] size,
    output logic [COORD_W-1:0] seg_rd_addr,
    input  logic [COORD_W-1:0] seg_rd_x,
    input  logic [COORD_W-1:0] seg_rd_y,
    output logic               busy,
    output logic               done,
    input  logic [COORD_W-1:0] cell_x,
    output logic               cell_hit,
    output logic               head_hit
);

    import snake_pkg::*;

    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    scan_state_t        state_q, state_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] size_q, size_d;
    logic [COORD_W-1:0] addr_q, addr_d;
    logic               issuing_q, issuing_d;
    logic               valid_q, valid_d;
    logic [COORD_W-1:0] idx_q, idx_d;

    logic               clear_build;
    logic               commit;
    logic               wr_en;
    logic               wr_head;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        size_d      = size_q;
        addr_d      = addr_q;
        issuing_d   = issuing_q;
        valid_d     = 1'b0;
        idx_d       = idx_q;
        clear_build = 1'b0;
        commit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (line_start) begin
                    row_d       = line_y;
                    size_d      = size;
                    addr_d      = '0;
                    clear_build = 1'b1;
                    if (size != '0) begin
                        issuing_d = 1'b1;
                        state_d   = ST_SCAN;
                    end else begin
                        state_d   = ST_COMMIT;
                    end
                end
            end
            ST_SCAN: begin
                // The cycle after the last issue is the drain cycle for its data.
                if (issuing_q) begin
                    valid_d = 1'b1;
                    idx_d   = addr_q;
                    if (addr_q == size_q - COORD_ONE) begin
                        issuing_d = 1'b0;
                    end else begin
                        addr_d = addr_q + COORD_ONE;
                    end
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            size_q    <= '0;
            addr_q    <= '0;
            issuing_q <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            issuing_q <= issuing_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
        end
    end

    assign wr_en   = valid_q && (seg_rd_y == row_q);
    assign wr_head = (idx_q == HEAD_IDX);

    assign seg_rd_addr = addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_COMMIT);

    snake_line_buffer #(
        .COORD_W (COORD_W),
        .GRID_W  (GRID_W)
    ) u_line_buffer (
        .clk         (clk),
        .reset       (reset),
        .clear_build (clear_build),
        .wr_en       (wr_en),
        .wr_head     (wr_head),
        .wr_x        (seg_rd_x),
        .commit      (commit),
        .cell_x      (cell_x),
        .cell_hit    (cell_hit),
        .head_hit    (head_hit)
    );

endmodule

`default_nettype wire

// File: tb/tb_snake_line_scanner.sv
// ============================================================================
// Module  : tb_snake_line_scanner
// Purpose : Self-checking bench for snake_line_scanner with a behavioural
//           segment store and a query scoreboard.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_snake_line_scanner;

    localparam int CW = 7;
    localparam int GW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start;
    logic [CW-1:0] line_y;
    logic [CW-1:0] size;
    logic [CW-1:0] seg_rd_addr;
    logic [CW-1:0] seg_rd_x;
    logic [CW-1:0] seg_rd_y;
    logic          busy;
    logic          done;
    logic [CW-1:0] cell_x;
    logic          cell_hit;
    logic          head_hit;

    always #5 clk = ~clk;

    snake_line_scanner #(
        .COORD_W (CW),
        .GRID_W  (GW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .line_y      (line_y),
        .size        (size),
        .seg_rd_addr (seg_rd_addr),
        .seg_rd_x    (seg_rd_x),
        .seg_rd_y    (seg_rd_y),
        .busy        (busy),
        .done        (done),
        .cell_x      (cell_x),
        .cell_hit    (cell_hit),
        .head_hit    (head_hit)
    );

    // Segment store with one cycle of read latency.
    logic [CW-1:0] mem_x [GW];
    logic [CW-1:0] mem_y [GW];

    always @(posedge clk) begin
        seg_rd_x <= mem_x[seg_rd_addr];
        seg_rd_y <= mem_y[seg_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [GW-1:0] exp_bits;
    logic          exp_hv;
    logic [CW-1:0] exp_hx;
    logic [1:0]    sb_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [CW-1:0] y, input int n);
        exp_bits = '0;
        exp_hv   = 1'b0;
        exp_hx   = '0;
        for (int i = 0; i < n; i++) begin
            if (mem_y[i] == y) begin
                exp_bits[mem_x[i]] = 1'b1;
                if (i == 0) begin
                    exp_hv = 1'b1;
                    exp_hx = mem_x[i];
                end
            end
        end
    endtask

    // Sweeps every cell; expectation pushed when cell_x is driven, popped a cycle later.
    task automatic query_all(input string tag);
        logic [1:0] e;
        for (int c = 0; c <= GW; c++) begin
            @(posedge clk); #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk($sformatf("%s[%0d]", tag, c - 1), {30'd0, cell_hit, head_hit}, {30'd0, e});
            end
            if (c < GW) begin
                cell_x = CW'(c);
                sb_q.push_back({exp_bits[c], exp_hv && (exp_hx == CW'(c))});
            end
        end
    endtask

    // track_old >= 0: cell_hit at the held cell_x must show that value until the swap.
    task automatic scan(input logic [CW-1:0] y, input int n, input int inject_at, input int track_old);
        int lat;
        int first;
        int pulses;
        int want;
        lat = (n == 0) ? 1 : n + 2;
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y     = y;
        size       = CW'(n);
        model(y, n);
        first  = -1;
        pulses = 0;
        for (int j = 1; j <= lat + 6; j++) begin
            @(posedge clk); #1;
            line_start = 1'b0;
            if (j == 1) begin
                line_y = y ^ 7'h55;
                size   = 7'h7f;
                chk("busy_start", {31'd0, busy}, 32'd1);
            end
            if (j == inject_at) begin
                line_start = 1'b1;
                line_y     = y + 7'd1;
                size       = 7'd3;
            end
            if (j <= n) chk($sformatf("rd_addr%0d", j - 1), {25'd0, seg_rd_addr}, j - 1);
            if (done) begin
                pulses++;
                if (first < 0) first = j;
            end
            if (track_old >= 0) begin
                want = (j <= lat + 1) ? track_old : int'(exp_bits[cell_x]);
                chk($sformatf("dbuf%0d", j), {31'd0, cell_hit}, want);
            end
        end
        chk("done_lat", first, lat);
        chk("done_cnt", pulses, 1);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        reset      = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        size       = '0;
        cell_x     = '0;
        for (int i = 0; i < GW; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_addr", {25'd0, seg_rd_addr}, 32'd0);
        chk("rst_hit",  {31'd0, cell_hit}, 32'd0);
        chk("rst_head", {31'd0, head_hit}, 32'd0);
        reset = 1'b0;

        // Single head segment.
        mem_x[0] = 7'd10; mem_y[0] = 7'd20;
        scan(7'd20, 1, 0, -1);
        query_all("head");

        // Row filtering, then double-buffer swap watched at cell 5.
        mem_x[0] = 7'd5; mem_y[0] = 7'd7;
        mem_x[1] = 7'd6; mem_y[1] = 7'd7;
        mem_x[2] = 7'd6; mem_y[2] = 7'd8;
        scan(7'd7, 3, 0, -1);
        query_all("row7");
        cell_x = 7'd5;
        scan(7'd8, 3, 0, 1);
        query_all("row8");

        // Empty scan commits an empty row.
        scan(7'd3, 0, 0, -1);
        query_all("empty");

        // A request while busy must be ignored.
        for (int i = 0; i < 10; i++) begin
            mem_x[i] = CW'(20 + i);
            mem_y[i] = 7'd30;
        end
        scan(7'd30, 10, 5, -1);
        query_all("busy_rule");

        // Longest scan, all segments stacked in the corner cell.
        for (int i = 0; i < GW; i++) begin
            mem_x[i] = 7'd127;
            mem_y[i] = 7'd0;
        end
        scan(7'd0, 127, 0, -1);
        query_all("full");

        // Reset in the middle of a scan aborts it and clears the display.
        @(posedge clk); #1;
        line_start = 1'b1;
        line_y     = 7'd0;
        size       = 7'd50;
        @(posedge clk); #1;
        line_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int j = 0; j < 70; j++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort_nodone", pulses, 0);
        exp_bits = '0;
        exp_hv   = 1'b0;
        exp_hx   = '0;
        query_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/snake_line_scanner.md
# snake_line_scanner

Read-side companion to the snake game state: each display row, it walks the snake segment coordinate store and builds a 128-cell occupancy bitmap for that row. The VGA pixel path then queries that bitmap per cell. The block sits between the segment X/Y storage (written by game logic) and the pixel colour mux. It is double-buffered, so one row is scanned while the previous row's bitmap is displayed.

## Interface
Parameters:
- COORD_W, 7, width of one grid coordinate; grid is 2^COORD_W cells per axis.
- GRID_W, 128, cells per row; must equal 2^COORD_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- line_start  in  1  single-cycle request to scan row line_y; honoured only when busy=0.
- line_y  in  COORD_W  grid row to scan; sampled with line_start.
- size  in  COORD_W  number of live segments (0..127); sampled with line_start.
- seg_rd_addr  out  COORD_W  segment index to read; segment 0 is the head.
- seg_rd_x  in  COORD_W  X of segment at seg_rd_addr, valid one cycle after the address.
- seg_rd_y  in  COORD_W  Y of segment at seg_rd_addr, valid one cycle after the address.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; display bitmap is committed at the end of this cycle.
- cell_x  in  COORD_W  cell column queried by the pixel path.
- cell_hit  out  1  registered; snake body occupies (cell_x, committed row).
- head_hit  out  1  registered; the head occupies (cell_x, committed row).

## Operation
- States: IDLE, SCAN, COMMIT.
- IDLE:
  - On line_start: latch line_y and size, clear build bitmap and head flag.
  - Go to SCAN if size>0; otherwise go to COMMIT.
- SCAN:
  - Issue seg_rd_addr = 0,1,…,size-1, one per cycle.
  - A one-stage valid/index pipeline tracks the returning data.
  - For each returned segment with seg_rd_y == latched row: set build[seg_rd_x].
  - If that segment's index is 0: also set head_valid and head_x = seg_rd_x.
  - After the last address issues, wait one cycle for the final data, then go to COMMIT.
- COMMIT:
  - done=1.
  - Copy build bitmap, head_valid and head_x into the display registers.
  - Return to IDLE.
- Duplicate or overlapping segments OR into the bitmap. No error is raised.
- line_start while busy=1 is ignored; the latched row and size are unaffected.
- Changes to size or line_y after they are sampled have no effect on the current scan.
- cell_hit(next cycle) = display[cell_x].
- head_hit(next cycle) = display_head_valid && display_head_x == cell_x.
- The display registers change only in COMMIT, so queries are stable for the whole row.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, seg_rd_addr=0.
  - cell_hit=0, head_hit=0.
  - Both bitmaps all-zero; head flags cleared.
- line_start is sampled at the edge ending cycle t.
- For size N>0:
  - busy=1 from cycle t+1 through t+2+N.
  - seg_rd_addr=k in cycle t+1+k.
  - Data for index k arrives in cycle t+2+k.
  - COMMIT/done in cycle t+2+N.
  - New bitmap is visible to queries from cycle t+3+N; the corresponding cell_hit value appears at t+4+N.
- For N=0: COMMIT in t+1, empty row committed.
- Worst case N=127: 129 cycles, which fits inside horizontal blanking at the pixel clock.
- Query latency: 1 cycle from cell_x to cell_hit/head_hit.
- seg_rd_addr holds its last value outside SCAN.
- Reset asserted mid-scan aborts immediately. The display bitmap is cleared; no done pulse is produced.

## Structure
- Shared snake_pkg:
  - COORD_W and GRID_W.
  - MAX_SEG = 128.
  - The scan state encoding.
  - The segment-0 head index constant.
- One natural sub-module: snake_line_buffer, holding the build and display bitmaps, head flags, the commit copy and the registered query port.
- The FSM and address pipeline stay in snake_line_scanner.

## Test plan
- Reset: mid-scan with size=50 → busy=0 next cycle; cell_hit=0 for all cell_x; no done pulse.
- Single head: size=1, seg0=(10,20), line_y=20.
  - done at t+3.
  - cell_x=10 → cell_hit=1, head_hit=1.
  - cell_x=11 → both 0.
- Row filter: size=3, segs (5,7),(6,7),(6,8), line_y=7.
  - Bits 5 and 6 set; head_hit only at 5.
  - Rescan with line_y=8 → only bit 6, head_hit=0 everywhere.
- Boundaries:
  - size=0 → done at t+1, empty row.
  - size=127, all segments at (127,0), line_y=0 → done at t+129; only bit 127 set.
- Busy rule: line_start at t+5 during a size=10 scan → ignored; single done at t+12; row unchanged.
- Double buffering: during the second scan, cell_hit keeps reporting the first row until that scan's done cycle, then switches.
